rename_regfile_mp: RTL and testbench
====================================

Name: rename_regfile_mp

Overview:
Multi-port architectural register file with register-renaming tags for the out-of-order core. It generalises the single-issue renamed register file to ISSUE_W issue slots per cycle, parametrised data width, register count and ROB tag width. It adds three new behaviours: intra-bundle dependency resolution, same-cycle commit bypass to issue reads, and a registered busy-register count. It sits between the dispatcher (read and rename) and the ROB (commit and rollback).

Parameters:
XLEN, 32, data width of each register
REG_NUM, 32, number of architectural registers; power of two, at least 2; RW = log2(REG_NUM) is a localparam
ROB_W, 4, ROB tag width
ISSUE_W, 2, issue/rename slots per cycle, 1..4; slot 0 is oldest
CNT_W localparam = log2(REG_NUM)+1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
rdy  in  1  global enable; state frozen when low
issue_valid  in  ISSUE_W  per-slot read enable
issue_rs1  in  ISSUE_W*RW  source 1 index, slot k at bits [k*RW +: RW]
issue_rs2  in  ISSUE_W*RW  source 2 index
issue_rd  in  ISSUE_W*RW  destination index
rename_valid  in  ISSUE_W  per-slot rename strobe
issue_rdTag  in  ISSUE_W*ROB_W  ROB tag for each slot's rd
issue_Qj, issue_Qk  out  ISSUE_W*ROB_W  dependency tags
issue_Vj, issue_Vk  out  ISSUE_W*XLEN  operand values
issue_Rj, issue_Rk  out  ISSUE_W  operand ready flags
commit_valid  in  1  ROB commit strobe
ROB_rd  in  RW  committing rd
ROB_rdTag  in  ROB_W  committing tag
ROB_rdVal  in  XLEN  committing value
rollback  in  1  mispredict flush
busy_count  out  CNT_W  number of busy registers (registered)

Behaviour:
- State: regVal[REG_NUM], regTag[REG_NUM], regBusy[REG_NUM], plus the busy_count register. Register 0 is never busy, never written, and always reads 0.
- Reset (rst=0, asynchronous): all values, tags and busy flags clear to 0; busy_count=0. Release is sampled on the next clk edge.
- Reads are combinational. Priority for slot k, source s (rs1 and rs2 are independent), first match wins:
  1. issue_valid[k]=0: Q=0, V=0, R=0.
  2. s==0: R=1, V=0, Q=0.
  3. Some j<k has rename_valid[j], issue_rd[j]==s, and s!=0. Use the largest such j. Output R=0, Q=issue_rdTag[j], V=0.
  4. regBusy[s], commit_valid, rollback=0, ROB_rd==s, and ROB_rdTag==regTag[s] (bypass): R=1, V=ROB_rdVal, Q=0.
  5. regBusy[s]: R=0, Q=regTag[s], V=0.
  6. Otherwise: R=1, V=regVal[s], Q=0.
- Read outputs do not depend on rdy.
- Sequential update at posedge, only when rdy=1:
  - Commit: if commit_valid and ROB_rd!=0, write regVal[ROB_rd]. This happens even when rollback=1.
  - Commit clears busy: if regBusy[ROB_rd] and the tag matches, clear busy and tag, unless a rename to the same rd occurs this cycle.
  - Rename: for each k with rename_valid[k] and issue_rd[k]!=0, set regTag=issue_rdTag[k] and regBusy=1. When several slots name the same rd, the highest slot wins. Rename beats the commit-clear on the same register.
  - Rollback: clear all busy flags and tags. Renames in that cycle are discarded. Values are kept, and the commit value write still applies.
  - busy_count takes the population count of the next-state regBusy. It equals 0 on reset, after rollback, and whenever no register is busy. It never exceeds REG_NUM-1.
- rdy=0: no state changes, including rename, commit and rollback; busy_count holds.
- Tags are opaque. There is no tag-0 special meaning; only regBusy defines readiness.

Test Plan:
- Reset then read: rst low, then issue_valid=2'b11 with rs1=5, rs2=0 on both slots. Required: R=1, V=0, Q=0 on all four operands; busy_count=0.
- Intra-bundle dependency: slot0 renames rd=3 with tag 7, slot1 reads rs1=3 in the same cycle. Required: slot1 Rj=0, Qj=7. Next cycle busy_count=1, and a read of x3 gives Q=7, R=0.
- Commit bypass: x3 busy with tag 7; commit_valid with ROB_rd=3, tag 7, value 0xDEADBEEF, while slot0 reads rs2=3. Required: Rk=1, Vk=0xDEADBEEF in that cycle. Next cycle x3 is not busy and regVal=0xDEADBEEF.
- Stale commit versus rename: x4 is busy with tag 2; commit x4 with tag 1 (mismatch) and value 9. Required: regVal[4]=9, x4 stays busy with Q=2. Second case: same-cycle commit of tag 2 plus rename of x4 to tag 5 → busy with Q=5.
- Same-rd double rename: slot0 and slot1 both rename rd=6, with tags 1 and 2. Required: regTag[6]=2, busy_count increments by 1 only.
- Rollback with commit, then rdy freeze: 3 registers busy; rollback=1 together with a commit of x8=0x55 and a rename of x9. Required: busy_count=0, x8=0x55, x9 not busy. Then rdy=0 with a rename pulse: no state change and busy_count holds.

Source files
------------

// File: rtl/rename_regfile_mp.sv
// Multi-issue renamed architectural register file: per-slot operand reads with
// intra-bundle forwarding and commit bypass, ROB commit/rollback, busy count.
module rename_regfile_mp #(
    parameter  int XLEN    = 32,
    parameter  int REG_NUM = 32,
    parameter  int ROB_W   = 4,
    parameter  int ISSUE_W = 2,
    localparam int RW      = $clog2(REG_NUM),
    localparam int CNT_W   = $clog2(REG_NUM) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic [ISSUE_W-1:0]       issue_valid,
    input  logic [ISSUE_W*RW-1:0]    issue_rs1,
    input  logic [ISSUE_W*RW-1:0]    issue_rs2,
    input  logic [ISSUE_W*RW-1:0]    issue_rd,
    input  logic [ISSUE_W-1:0]       rename_valid,
    input  logic [ISSUE_W*ROB_W-1:0] issue_rdTag,
    output logic [ISSUE_W*ROB_W-1:0] issue_Qj,
    output logic [ISSUE_W*ROB_W-1:0] issue_Qk,
    output logic [ISSUE_W*XLEN-1:0]  issue_Vj,
    output logic [ISSUE_W*XLEN-1:0]  issue_Vk,
    output logic [ISSUE_W-1:0]       issue_Rj,
    output logic [ISSUE_W-1:0]       issue_Rk,
    input  logic                     commit_valid,
    input  logic [RW-1:0]            ROB_rd,
    input  logic [ROB_W-1:0]         ROB_rdTag,
    input  logic [XLEN-1:0]          ROB_rdVal,
    input  logic                     rollback,
    output logic [CNT_W-1:0]         busy_count
);

    logic [XLEN-1:0]    regVal_q [REG_NUM];
    logic [XLEN-1:0]    regVal_d [REG_NUM];
    logic [ROB_W-1:0]   regTag_q [REG_NUM];
    logic [ROB_W-1:0]   regTag_d [REG_NUM];
    logic [REG_NUM-1:0] regBusy_q;
    logic [REG_NUM-1:0] regBusy_d;
    logic [CNT_W-1:0]   busyCount_q;
    logic [CNT_W-1:0]   busyCount_d;

    logic [RW-1:0]    src;
    logic             fwdHit;
    logic [ROB_W-1:0] fwdTag;
    logic             opR;
    logic [ROB_W-1:0] opQ;
    logic [XLEN-1:0]  opV;
    logic [RW-1:0]    renRd;

    // Operand lookup: an older slot's rename in the same bundle shadows the
    // register file, and a matching non-flushed commit is forwarded directly.
    always_comb begin
        issue_Qj = '0;
        issue_Qk = '0;
        issue_Vj = '0;
        issue_Vk = '0;
        issue_Rj = '0;
        issue_Rk = '0;
        src      = '0;
        fwdHit   = 1'b0;
        fwdTag   = '0;
        opR      = 1'b0;
        opQ      = '0;
        opV      = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            for (int s = 0; s < 2; s++) begin
                src    = (s == 0) ? issue_rs1[k*RW +: RW] : issue_rs2[k*RW +: RW];
                fwdHit = 1'b0;
                fwdTag = '0;
                opR    = 1'b0;
                opQ    = '0;
                opV    = '0;
                for (int j = 0; j < k; j++) begin
                    if (rename_valid[j] && (issue_rd[j*RW +: RW] == src)) begin
                        fwdHit = 1'b1;
                        fwdTag = issue_rdTag[j*ROB_W +: ROB_W];
                    end
                end
                if (!issue_valid[k]) begin
                    opR = 1'b0;
                end else if (src == '0) begin
                    opR = 1'b1;
                end else if (fwdHit) begin
                    opQ = fwdTag;
                end else if (regBusy_q[src] && commit_valid && !rollback &&
                             (ROB_rd == src) && (ROB_rdTag == regTag_q[src])) begin
                    opR = 1'b1;
                    opV = ROB_rdVal;
                end else if (regBusy_q[src]) begin
                    opQ = regTag_q[src];
                end else begin
                    opR = 1'b1;
                    opV = regVal_q[src];
                end
                if (s == 0) begin
                    issue_Rj[k]                 = opR;
                    issue_Qj[k*ROB_W +: ROB_W]  = opQ;
                    issue_Vj[k*XLEN +: XLEN]    = opV;
                end else begin
                    issue_Rk[k]                 = opR;
                    issue_Qk[k*ROB_W +: ROB_W]  = opQ;
                    issue_Vk[k*XLEN +: XLEN]    = opV;
                end
            end
        end
    end

    // Next state: value write always lands; rollback wipes renaming, otherwise
    // commit-clear is applied first so a same-register rename overrides it.
    always_comb begin
        for (int i = 0; i < REG_NUM; i++) begin
            regVal_d[i] = regVal_q[i];
            regTag_d[i] = regTag_q[i];
        end
        regBusy_d = regBusy_q;
        renRd     = '0;
        if (commit_valid && (ROB_rd != '0)) begin
            regVal_d[ROB_rd] = ROB_rdVal;
        end
        if (rollback) begin
            regBusy_d = '0;
            for (int i = 0; i < REG_NUM; i++) begin
                regTag_d[i] = '0;
            end
        end else begin
            if (commit_valid && regBusy_q[ROB_rd] && (regTag_q[ROB_rd] == ROB_rdTag)) begin
                regBusy_d[ROB_rd] = 1'b0;
                regTag_d[ROB_rd]  = '0;
            end
            for (int k = 0; k < ISSUE_W; k++) begin
                renRd = issue_rd[k*RW +: RW];
                if (rename_valid[k] && (renRd != '0)) begin
                    regTag_d[renRd]  = issue_rdTag[k*ROB_W +: ROB_W];
                    regBusy_d[renRd] = 1'b1;
                end
            end
        end
        regBusy_d[0] = 1'b0;
        busyCount_d  = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            busyCount_d = busyCount_d + CNT_W'(regBusy_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regVal_q[i] <= '0;
                regTag_q[i] <= '0;
            end
            regBusy_q   <= '0;
            busyCount_q <= '0;
        end else if (rdy) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regVal_q[i] <= regVal_d[i];
                regTag_q[i] <= regTag_d[i];
            end
            regBusy_q   <= regBusy_d;
            busyCount_q <= busyCount_d;
        end
    end

    assign busy_count = busyCount_q;

endmodule

// File: tb/tb_rename_regfile_mp.sv
// Bench for rename_regfile_mp: directed vector table, then randomized traffic
// compared against an array-based reference model of the register file.
module tb_rename_regfile_mp;

    localparam int XLEN    = 32;
    localparam int REG_NUM = 32;
    localparam int ROB_W   = 4;
    localparam int ISSUE_W = 2;
    localparam int RW      = 5;
    localparam int CNT_W   = 6;

    logic                     clk;
    logic                     rst;
    logic                     rdy;
    logic [ISSUE_W-1:0]       issue_valid;
    logic [ISSUE_W*RW-1:0]    issue_rs1;
    logic [ISSUE_W*RW-1:0]    issue_rs2;
    logic [ISSUE_W*RW-1:0]    issue_rd;
    logic [ISSUE_W-1:0]       rename_valid;
    logic [ISSUE_W*ROB_W-1:0] issue_rdTag;
    logic [ISSUE_W*ROB_W-1:0] issue_Qj;
    logic [ISSUE_W*ROB_W-1:0] issue_Qk;
    logic [ISSUE_W*XLEN-1:0]  issue_Vj;
    logic [ISSUE_W*XLEN-1:0]  issue_Vk;
    logic [ISSUE_W-1:0]       issue_Rj;
    logic [ISSUE_W-1:0]       issue_Rk;
    logic                     commit_valid;
    logic [RW-1:0]            ROB_rd;
    logic [ROB_W-1:0]         ROB_rdTag;
    logic [XLEN-1:0]          ROB_rdVal;
    logic                     rollback;
    logic [CNT_W-1:0]         busy_count;

    int checks = 0;
    int errors = 0;

    rename_regfile_mp #(
        .XLEN(XLEN), .REG_NUM(REG_NUM), .ROB_W(ROB_W), .ISSUE_W(ISSUE_W)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .rename_valid(rename_valid), .issue_rdTag(issue_rdTag),
        .issue_Qj(issue_Qj), .issue_Qk(issue_Qk), .issue_Vj(issue_Vj), .issue_Vk(issue_Vk),
        .issue_Rj(issue_Rj), .issue_Rk(issue_Rk),
        .commit_valid(commit_valid), .ROB_rd(ROB_rd), .ROB_rdTag(ROB_rdTag),
        .ROB_rdVal(ROB_rdVal), .rollback(rollback), .busy_count(busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [9:0]  rs1;
        logic [9:0]  rs2;
        logic [9:0]  rd;
        logic [1:0]  renV;
        logic [7:0]  rdTag;
        logic        cv;
        logic [4:0]  robRd;
        logic [3:0]  robTag;
        logic [31:0] robVal;
        logic        rb;
        logic        rdyv;
        logic [1:0]  eRj;
        logic [1:0]  eRk;
        logic [7:0]  eQj;
        logic [7:0]  eQk;
        logic [63:0] eVj;
        logic [63:0] eVk;
        logic [5:0]  eCnt;
    } vec_t;

    vec_t tbl[$];
    vec_t cur;

    logic [31:0] mVal [REG_NUM];
    logic [3:0]  mTag [REG_NUM];
    bit          mBusy[REG_NUM];

    task automatic newVec();
        cur = '{default: '0};
        cur.rdyv = 1'b1;
    endtask

    task automatic setRead(input logic [1:0] v, input logic [4:0] a1, a2, b1, b2);
        cur.valid = v;
        cur.rs1   = {b1, a1};
        cur.rs2   = {b2, a2};
    endtask

    task automatic setRen(input logic [1:0] en, input logic [4:0] rd0, input logic [3:0] t0,
                          input logic [4:0] rd1, input logic [3:0] t1);
        cur.renV  = en;
        cur.rd    = {rd1, rd0};
        cur.rdTag = {t1, t0};
    endtask

    task automatic setCommit(input logic [4:0] rd, input logic [3:0] tag, input logic [31:0] val);
        cur.cv     = 1'b1;
        cur.robRd  = rd;
        cur.robTag = tag;
        cur.robVal = val;
    endtask

    task automatic pushExp(input logic [1:0] rj, rk, input logic [7:0] qj, qk,
                           input logic [63:0] vj, vk, input logic [5:0] cnt);
        cur.eRj  = rj;
        cur.eRk  = rk;
        cur.eQj  = qj;
        cur.eQk  = qk;
        cur.eVj  = vj;
        cur.eVk  = vk;
        cur.eCnt = cnt;
        tbl.push_back(cur);
    endtask

    task automatic applyStimulus(input vec_t v);
        issue_valid  = v.valid;
        issue_rs1    = v.rs1;
        issue_rs2    = v.rs2;
        issue_rd     = v.rd;
        rename_valid = v.renV;
        issue_rdTag  = v.rdTag;
        commit_valid = v.cv;
        ROB_rd       = v.robRd;
        ROB_rdTag    = v.robTag;
        ROB_rdVal    = v.robVal;
        rollback     = v.rb;
        rdy          = v.rdyv;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Reference read: walk older slots youngest-first, then bypass, then the file.
    function automatic void modelRead(input int k, input logic [4:0] s,
                                      output logic r, output logic [3:0] q, output logic [31:0] v);
        r = 1'b0;
        q = '0;
        v = '0;
        if (!issue_valid[k]) return;
        if (s == 0) begin
            r = 1'b1;
            return;
        end
        for (int j = k - 1; j >= 0; j--) begin
            if (rename_valid[j] && issue_rd[j*RW +: RW] == s) begin
                q = issue_rdTag[j*ROB_W +: ROB_W];
                return;
            end
        end
        if (mBusy[s] && commit_valid && !rollback && ROB_rd == s && ROB_rdTag == mTag[s]) begin
            r = 1'b1;
            v = ROB_rdVal;
            return;
        end
        if (mBusy[s]) begin
            q = mTag[s];
            return;
        end
        r = 1'b1;
        v = mVal[s];
    endfunction

    task automatic compareModel(input int cyc);
        logic [1:0]  eRj, eRk;
        logic [7:0]  eQj, eQk;
        logic [63:0] eVj, eVk;
        logic        r;
        logic [3:0]  q;
        logic [31:0] v;
        for (int k = 0; k < ISSUE_W; k++) begin
            modelRead(k, issue_rs1[k*RW +: RW], r, q, v);
            eRj[k] = r; eQj[k*4 +: 4] = q; eVj[k*32 +: 32] = v;
            modelRead(k, issue_rs2[k*RW +: RW], r, q, v);
            eRk[k] = r; eQk[k*4 +: 4] = q; eVk[k*32 +: 32] = v;
        end
        checkOutput($sformatf("rnd%0d Rj", cyc), 64'(issue_Rj), 64'(eRj));
        checkOutput($sformatf("rnd%0d Rk", cyc), 64'(issue_Rk), 64'(eRk));
        checkOutput($sformatf("rnd%0d Qj", cyc), 64'(issue_Qj), 64'(eQj));
        checkOutput($sformatf("rnd%0d Qk", cyc), 64'(issue_Qk), 64'(eQk));
        checkOutput($sformatf("rnd%0d Vj", cyc), issue_Vj, eVj);
        checkOutput($sformatf("rnd%0d Vk", cyc), issue_Vk, eVk);
    endtask

    task automatic modelUpdate();
        if (!rdy) return;
        if (commit_valid && ROB_rd != 0) mVal[ROB_rd] = ROB_rdVal;
        if (rollback) begin
            for (int i = 0; i < REG_NUM; i++) begin
                mBusy[i] = 1'b0;
                mTag[i]  = '0;
            end
            return;
        end
        if (commit_valid && mBusy[ROB_rd] && mTag[ROB_rd] == ROB_rdTag) mBusy[ROB_rd] = 1'b0;
        for (int k = 0; k < ISSUE_W; k++) begin
            if (rename_valid[k] && issue_rd[k*RW +: RW] != 0) begin
                mBusy[issue_rd[k*RW +: RW]] = 1'b1;
                mTag[issue_rd[k*RW +: RW]]  = issue_rdTag[k*ROB_W +: ROB_W];
            end
        end
    endtask

    function automatic int modelCount();
        int n = 0;
        for (int i = 0; i < REG_NUM; i++) n += int'(mBusy[i]);
        return n;
    endfunction

    initial begin
        #2000000;
        $display("[TB] FAIL timeout act=running exp=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        newVec();
        cur.rdyv = 1'b0;
        applyStimulus(cur);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetCount", 64'(busy_count), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        newVec(); setRead(2'b11, 5, 0, 5, 0);
        pushExp(2'b11, 2'b11, 8'h00, 8'h00, 64'h0, 64'h0, 6'd0);
        newVec(); setRead(2'b11, 0, 0, 3, 0); setRen(2'b01, 3, 7, 0, 0);
        pushExp(2'b01, 2'b11, 8'h70, 8'h00, 64'h0, 64'h0, 6'd1);
        newVec(); setRead(2'b01, 3, 3, 0, 0);
        pushExp(2'b00, 2'b00, 8'h07, 8'h07, 64'h0, 64'h0, 6'd1);
        newVec(); setRead(2'b01, 0, 3, 0, 0); setCommit(3, 7, 32'hDEADBEEF);
        pushExp(2'b01, 2'b01, 8'h00, 8'h00, 64'h0, 64'hDEADBEEF, 6'd0);
        newVec(); setRead(2'b01, 3, 0, 0, 0);
        pushExp(2'b01, 2'b01, 8'h00, 8'h00, 64'hDEADBEEF, 64'h0, 6'd0);
        newVec(); setRen(2'b01, 4, 2, 0, 0);
        pushExp(2'b00, 2'b00, 8'h00, 8'h00, 64'h0, 64'h0, 6'd1);
        newVec(); setRead(2'b01, 4, 0, 0, 0); setCommit(4, 1, 32'd9);
        pushExp(2'b00, 2'b01, 8'h02, 8'h00, 64'h0, 64'h0, 6'd1);
        newVec(); setRead(2'b01, 4, 4, 0, 0);
        pushExp(2'b00, 2'b00, 8'h02, 8'h02, 64'h0, 64'h0, 6'd1);
        newVec(); setCommit(4, 2, 32'd9); setRen(2'b01, 4, 5, 0, 0);
        pushExp(2'b00, 2'b00, 8'h00, 8'h00, 64'h0, 64'h0, 6'd1);
        newVec(); setRead(2'b01, 4, 0, 0, 0);
        pushExp(2'b00, 2'b01, 8'h05, 8'h00, 64'h0, 64'h0, 6'd1);
        newVec(); cur.rb = 1'b1;
        pushExp(2'b00, 2'b00, 8'h00, 8'h00, 64'h0, 64'h0, 6'd0);
        newVec(); setRead(2'b01, 4, 3, 0, 0);
        pushExp(2'b01, 2'b01, 8'h00, 8'h00, 64'h9, 64'hDEADBEEF, 6'd0);
        newVec(); setRead(2'b10, 0, 0, 6, 0); setRen(2'b11, 6, 1, 6, 2);
        pushExp(2'b00, 2'b10, 8'h10, 8'h00, 64'h0, 64'h0, 6'd1);
        newVec(); setRead(2'b01, 6, 6, 0, 0);
        pushExp(2'b00, 2'b00, 8'h02, 8'h02, 64'h0, 64'h0, 6'd1);
        newVec(); setRen(2'b11, 8, 3, 10, 4);
        pushExp(2'b00, 2'b00, 8'h00, 8'h00, 64'h0, 64'h0, 6'd3);
        newVec(); setRead(2'b01, 8, 6, 0, 0); setCommit(8, 3, 32'h55); setRen(2'b01, 9, 6, 0, 0);
        cur.rb = 1'b1;
        pushExp(2'b00, 2'b00, 8'h03, 8'h02, 64'h0, 64'h0, 6'd0);
        newVec(); setRead(2'b11, 8, 9, 6, 0);
        pushExp(2'b11, 2'b11, 8'h00, 8'h00, 64'h55, 64'h0, 6'd0);
        newVec(); cur.rdyv = 1'b0; setRen(2'b01, 12, 9, 0, 0); setCommit(5, 0, 32'h77);
        pushExp(2'b00, 2'b00, 8'h00, 8'h00, 64'h0, 64'h0, 6'd0);
        newVec(); setRead(2'b01, 12, 5, 0, 0);
        pushExp(2'b01, 2'b01, 8'h00, 8'h00, 64'h0, 64'h0, 6'd0);
        newVec(); setRen(2'b01, 12, 9, 0, 0);
        pushExp(2'b00, 2'b00, 8'h00, 8'h00, 64'h0, 64'h0, 6'd1);
        newVec(); cur.rdyv = 1'b0; cur.rb = 1'b1; setRead(2'b01, 12, 0, 0, 0); setRen(2'b01, 13, 3, 0, 0);
        pushExp(2'b00, 2'b01, 8'h09, 8'h00, 64'h0, 64'h0, 6'd1);
        newVec(); setRead(2'b01, 12, 13, 0, 0);
        pushExp(2'b00, 2'b01, 8'h09, 8'h00, 64'h0, 64'h0, 6'd1);

        foreach (tbl[i]) begin
            @(negedge clk);
            applyStimulus(tbl[i]);
            #2;
            checkOutput($sformatf("vec%0d Rj", i), 64'(issue_Rj), 64'(tbl[i].eRj));
            checkOutput($sformatf("vec%0d Rk", i), 64'(issue_Rk), 64'(tbl[i].eRk));
            checkOutput($sformatf("vec%0d Qj", i), 64'(issue_Qj), 64'(tbl[i].eQj));
            checkOutput($sformatf("vec%0d Qk", i), 64'(issue_Qk), 64'(tbl[i].eQk));
            checkOutput($sformatf("vec%0d Vj", i), issue_Vj, tbl[i].eVj);
            checkOutput($sformatf("vec%0d Vk", i), issue_Vk, tbl[i].eVk);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d busyCount", i), 64'(busy_count), 64'(tbl[i].eCnt));
        end

        // Asynchronous reset mid-cycle must clear the count before any edge.
        @(negedge clk);
        newVec();
        applyStimulus(cur);
        rst = 1'b0;
        #2;
        checkOutput("asyncResetCount", 64'(busy_count), 64'd0);
        for (int i = 0; i < REG_NUM; i++) begin
            mVal[i]  = '0;
            mTag[i]  = '0;
            mBusy[i] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;

        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            issue_valid  = 2'($urandom);
            rename_valid = 2'($urandom);
            issue_rdTag  = 8'($urandom);
            for (int k = 0; k < ISSUE_W; k++) begin
                issue_rs1[k*RW +: RW] = 5'($urandom_range(0, 7));
                issue_rs2[k*RW +: RW] = 5'($urandom_range(0, 7));
                issue_rd[k*RW +: RW]  = 5'($urandom_range(0, 7));
            end
            commit_valid = ($urandom_range(0, 1) == 1);
            ROB_rd       = 5'($urandom_range(0, 7));
            ROB_rdTag    = ($urandom_range(0, 2) != 0) ? mTag[ROB_rd] : 4'($urandom);
            ROB_rdVal    = $urandom;
            rollback     = ($urandom_range(0, 19) == 0);
            rdy          = ($urandom_range(0, 9) != 0);
            #2;
            compareModel(c);
            @(posedge clk);
            modelUpdate();
            #1;
            checkOutput($sformatf("rnd%0d busyCount", c), 64'(busy_count), 64'(modelCount()));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
